// File: rtl/gonso_sequencer.sv
// Playback sequencer: walks SRAM port 1 from w_first to w_last, w_count times,
// streaming each byte on a valid/ready interface with a programmable inter-word gap.
module gonso_sequencer #(
   parameter int ASIZE = 32,
   parameter int PSIZE = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [ASIZE-1:0] w_first,
   input  logic [ASIZE-1:0] w_last,
   input  logic [3:0]       w_count,
   input  logic [PSIZE-1:0] prescale,
   output logic             progress,
   output logic             done,
   output logic             cs_n,
   output logic [ASIZE-1:0] addr,
   input  logic [7:0]       rdata,
   output logic             out_valid,
   output logic [7:0]       out_data,
   input  logic             out_ready
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_READ    = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_PRESENT = 3'd3;
   localparam logic [2:0] S_GAP     = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [ASIZE-1:0] idx_q, idx_d;
   logic [ASIZE-1:0] first_q, first_d;
   logic [ASIZE-1:0] last_q, last_d;
   logic [3:0]       pass_q, pass_d;
   logic [3:0]       count_q, count_d;
   logic [PSIZE-1:0] prescale_q, prescale_d;
   logic [PSIZE-1:0] gap_q, gap_d;
   logic             done_q, done_d;
   logic             progress_q;
   logic             cs_n_q;
   logic [ASIZE-1:0] addr_q;
   logic             out_valid_q;
   logic [7:0]       out_data_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_d    = state_q;
      idx_d      = idx_q;
      pass_d     = pass_q;
      gap_d      = gap_q;
      first_d    = first_q;
      last_d     = last_q;
      count_d    = count_q;
      prescale_d = prescale_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (w_count != 4'd0) begin
                  first_d    = w_first;
                  last_d     = w_last;
                  count_d    = w_count;
                  prescale_d = prescale;
                  idx_d      = w_first;
                  pass_d     = 4'd1;
                  state_d    = S_READ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_READ:  state_d = S_WAIT;
         S_WAIT:  state_d = S_PRESENT;
         S_PRESENT: begin
            if (out_ready) begin
               if (idx_q == last_q && pass_q >= count_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  // Index arithmetic is modulo 2^ASIZE, so a reversed range wraps through 0.
                  if (idx_q != last_q) begin
                     idx_d = idx_q + ASIZE'(1);
                  end else begin
                     idx_d  = first_q;
                     pass_d = pass_q + 4'd1;
                  end
                  if (prescale_q != '0) begin
                     state_d = S_GAP;
                     gap_d   = prescale_q;
                  end else begin
                     state_d = S_READ;
                  end
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - PSIZE'(1);
            if (gap_q <= PSIZE'(1)) state_d = S_READ;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         first_q     <= '0;
         last_q      <= '0;
         pass_q      <= '0;
         count_q     <= '0;
         prescale_q  <= '0;
         gap_q       <= '0;
         done_q      <= 1'b0;
         progress_q  <= 1'b0;
         cs_n_q      <= 1'b1;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         first_q     <= first_d;
         last_q      <= last_d;
         pass_q      <= pass_d;
         count_q     <= count_d;
         prescale_q  <= prescale_d;
         gap_q       <= gap_d;
         done_q      <= done_d;
         // Outputs are decoded from the next state so they are registered yet aligned with it.
         progress_q  <= (state_d != S_IDLE);
         cs_n_q      <= (state_d != S_READ);
         out_valid_q <= (state_d == S_PRESENT);
         if (state_d == S_READ) addr_q <= idx_d;
         if (state_q == S_WAIT) out_data_q <= rdata;
      end
   end

   assign progress  = progress_q;
   assign done      = done_q;
   assign cs_n      = cs_n_q;
   assign addr      = addr_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_gonso_sequencer.sv
// Self-checking bench for gonso_sequencer: table-driven walks, corner-case sequences,
// and randomized walks with random backpressure checked against a stream model.
module tb_gonso_sequencer;

   localparam int AW = 4;
   localparam int PW = 8;
   localparam int BUDGET = 3000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] w_first = '0;
   logic [AW-1:0] w_last = '0;
   logic [3:0]    w_count = '0;
   logic [PW-1:0] prescale = '0;
   logic          progress, done, cs_n, out_valid;
   logic [AW-1:0] addr;
   logic [7:0]    rdata = '0;
   logic [7:0]    out_data;
   logic          out_ready = 1'b0;

   logic [7:0] mem [16];

   int checks = 0;
   int errors = 0;

   gonso_sequencer #(.ASIZE(AW), .PSIZE(PW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .w_first(w_first), .w_last(w_last), .w_count(w_count), .prescale(prescale),
      .progress(progress), .done(done), .cs_n(cs_n), .addr(addr),
      .rdata(rdata), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // SRAM read port: data appears the cycle after cs_n is low.
   always @(posedge clk) if (!cs_n) rdata <= mem[addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one sequence from start to a few cycles after done; returns words and progress cycles.
   task automatic run_seq(input logic [AW-1:0] f, input logic [AW-1:0] l, input logic [3:0] cnt,
                          input logic [PW-1:0] pre, input bit rnd, input int disturb,
                          output int words, output int nprog);
      logic [7:0]    exp_d[$];
      logic [AW-1:0] exp_a[$];
      int len, nreads, ndone, done_cyc, last_xfer, first_valid, cyc;
      bit held, rdy;
      logic [7:0] held_data;
      len = int'(4'(l - f)) + 1;
      for (int p = 0; p < int'(cnt); p++)
         for (int k = 0; k < len; k++) begin
            exp_a.push_back(4'(f + 4'(k)));
            exp_d.push_back(mem[4'(f + 4'(k))]);
         end
      words = 0; nprog = 0; nreads = 0; ndone = 0; done_cyc = -1; last_xfer = -1;
      first_valid = -1; held = 0; held_data = '0;
      w_first = f; w_last = l; w_count = cnt; prescale = pre;
      out_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (cyc = 1; cyc < BUDGET; cyc++) begin
         start = 1'b0;
         if (progress) nprog++;
         if (done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (!cs_n) begin
            if (nreads < exp_a.size()) check("read_addr", addr, exp_a[nreads]);
            nreads++;
         end
         if (held) begin
            check("valid_held", out_valid, 1);
            check("data_held", out_data, held_data);
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         rdy = rnd ? 1'($urandom % 2) : 1'b1;
         out_ready = rdy;
         if (out_valid && rdy) begin
            if (words < exp_d.size()) check("stream_byte", out_data, exp_d[words]);
            if (!rnd && words == 0) check("first_xfer_cycle", cyc, 3);
            if (!rnd && words > 0) check("xfer_spacing", cyc - last_xfer, 3 + int'(pre));
            last_xfer = cyc;
            words++;
            held = 0;
         end else if (out_valid) begin
            held = 1;
            held_data = out_data;
         end else begin
            held = 0;
         end
         if (cyc == disturb && done_cyc < 0) begin
            start = 1'b1;
            w_last = 4'($urandom);
            prescale = 8'($urandom % 7);
            w_count = 4'($urandom);
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
         step();
      end
      start = 1'b0;
      if (done_cyc < 0) begin
         errors++;
         $display("FAIL seq_timeout: no done within %0d cycles", BUDGET);
      end else begin
         check("first_valid_cycle", first_valid, 3);
         check("done_cycle", done_cyc, last_xfer + 1);
         check("done_count", ndone, 1);
         check("progress_cycles", nprog, done_cyc - 1);
         check("read_count", nreads, exp_d.size());
         check("word_count", words, exp_d.size());
      end
   endtask

   typedef struct {
      logic [AW-1:0] f;
      logic [AW-1:0] l;
      logic [3:0]    cnt;
      logic [PW-1:0] pre;
      int            disturb;
      int            exp_words;
      int            exp_prog;
   } vec_t;

   initial begin
      vec_t vecs[6];
      int words, nprog, n;

      vecs[0] = '{4'd4,  4'd7,  4'd1, 8'd0, -1, 4,  12};
      vecs[1] = '{4'd4,  4'd7,  4'd3, 8'd5, 20, 12, 91};
      vecs[2] = '{4'd14, 4'd1,  4'd1, 8'd0, -1, 4,  12};
      vecs[3] = '{4'd5,  4'd5,  4'd2, 8'd1, 2,  2,  7};
      vecs[4] = '{4'd0,  4'd15, 4'd1, 8'd2, 30, 16, 78};
      vecs[5] = '{4'd9,  4'd9,  4'd1, 8'd0, -1, 1,  3};

      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;

      reset = 1'b1;
      step(); step();
      check("rst_progress", progress, 0);
      check("rst_done", done, 0);
      check("rst_cs_n", cs_n, 1);
      check("rst_addr", addr, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 6; i++) begin
         run_seq(vecs[i].f, vecs[i].l, vecs[i].cnt, vecs[i].pre, 1'b0, vecs[i].disturb, words, nprog);
         check("vec_words", words, vecs[i].exp_words);
         check("vec_progress", nprog, vecs[i].exp_prog);
      end

      // Wrap with random backpressure.
      run_seq(4'd14, 4'd1, 4'd1, 8'd0, 1'b1, -1, words, nprog);
      check("wrap_words", words, 4);

      // Zero count: done pulses in cycle 1, no reads, no progress.
      w_count = 4'd0; w_first = 4'd4; w_last = 4'd7; start = 1'b1;
      step();
      start = 1'b0;
      check("zero_done", done, 1);
      check("zero_progress", progress, 0);
      check("zero_cs_n", cs_n, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("zero_done_after", done, 0);
         check("zero_cs_n_after", cs_n, 1);
         check("zero_progress_after", progress, 0);
      end

      // Abort while stalled in PRESENT, then replay.
      for (int pass = 0; pass < 2; pass++) begin
         w_first = 4'd4; w_last = 4'd7; w_count = 4'd1; prescale = 8'd0;
         out_ready = 1'b0; start = 1'b1;
         step();
         start = 1'b0;
         n = 0;
         while (!out_valid && n < 20) begin step(); n++; end
         check("stop_reach_present", out_valid, 1);
         step();
         check("stop_stalled_valid", out_valid, 1);
         if (pass == 0) abort = 1'b1; else reset = 1'b1;
         step();
         abort = 1'b0; reset = 1'b0;
         check("stop_valid", out_valid, 0);
         check("stop_progress", progress, 0);
         check("stop_cs_n", cs_n, 1);
         check("stop_done", done, 0);
         if (pass == 1) begin
            check("stop_rst_addr", addr, 0);
            check("stop_rst_data", out_data, 0);
         end
         for (int i = 0; i < 3; i++) begin
            step();
            check("stop_done_after", done, 0);
            check("stop_progress_after", progress, 0);
         end
         run_seq(4'd4, 4'd7, 4'd1, 8'd0, 1'b0, -1, words, nprog);
         check("replay_words", words, 4);
      end

      // Abort coinciding with the final transfer suppresses done.
      w_first = 4'd9; w_last = 4'd9; w_count = 4'd1; prescale = 8'd0;
      out_ready = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      check("final_abort_present", out_valid, 1);
      out_ready = 1'b1; abort = 1'b1;
      step();
      abort = 1'b0;
      check("final_abort_done", done, 0);
      check("final_abort_valid", out_valid, 0);
      step();
      check("final_abort_done2", done, 0);

      // Start together with abort in IDLE is dropped.
      w_first = 4'd4; w_last = 4'd7; w_count = 4'd1; start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("start_abort_progress", progress, 0);
      check("start_abort_cs_n", cs_n, 1);
      step();
      check("start_abort_progress2", progress, 0);
      check("start_abort_cs_n2", cs_n, 1);
      check("start_abort_done", done, 0);

      // Randomized walks with backpressure and mid-run disturbance.
      for (int t = 0; t < 6; t++) begin
         logic [AW-1:0] f, l;
         logic [3:0] c;
         logic [PW-1:0] p;
         f = 4'($urandom); l = 4'($urandom);
         c = 4'(1 + $urandom % 3); p = 8'($urandom % 4);
         run_seq(f, l, c, p, 1'b1, 5 + int'($urandom % 25), words, nprog);
         check("rand_words", words, int'(c) * (int'(4'(l - f)) + 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
